systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 25 ++
 rtl/systolic_feeder.sv | 87 ++++++++
 tb/tb_systolic_feeder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: operand-load, array-feed and tile-done signals of systolic_feeder
//   slave  : feeder side, drives wr_ready, array_clear, feed_valid, feed_data, busy, done
//   master : producer/consumer side, drives wr_valid, wr_data, done_ack
interface systolic_feeder_if #(
    parameter int DATA_SIZE = 8,
    parameter int DIM = 4
);
    logic wr_valid;
    logic wr_ready;
    logic [DIM*DATA_SIZE-1:0] wr_data;
    logic array_clear;
    logic feed_valid;
    logic [DIM*DATA_SIZE-1:0] feed_data;
    logic busy;
    logic done;
    logic done_ack;
    modport slave (
        input wr_valid, wr_data, done_ack,
        output wr_ready, array_clear, feed_valid, feed_data, busy, done
    );
    modport master (
        output wr_valid, wr_data, done_ack,
        input wr_ready, array_clear, feed_valid, feed_data, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers DEPTH operand vectors, then streams them diagonally skewed into a DIM-lane systolic array
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : systolic_feeder_if.slave (load handshake, array feed, done/done_ack)
module systolic_feeder #(
    parameter int DATA_SIZE = 8,
    parameter int DIM = 4,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    systolic_feeder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 2 * DIM + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FILL_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(DEPTH + DIM - 2);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(DIM - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    typedef enum logic [2:0] {FILL, CLEAR, STREAM, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DIM*DATA_SIZE-1:0] mem [DEPTH];
    logic [DIM*DATA_SIZE-1:0] feed_n;
    logic accept;
    assign accept = bus.wr_valid && bus.wr_ready;
    // cnt is the fill index in FILL, the step t in STREAM and the flush cycle in FLUSH
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            FILL: if (accept) begin
                state_n = cnt == FILL_LAST ? CLEAR : FILL;
                cnt_n = cnt == FILL_LAST ? '0 : cnt + 1'b1;
            end
            CLEAR: begin
                state_n = STREAM;
                cnt_n = '0;
            end
            STREAM: begin
                state_n = cnt == STREAM_LAST ? FLUSH : STREAM;
                cnt_n = cnt == STREAM_LAST ? '0 : cnt + 1'b1;
            end
            FLUSH: begin
                state_n = cnt == FLUSH_LAST ? DONE : FLUSH;
                cnt_n = cnt == FLUSH_LAST ? '0 : cnt + 1'b1;
            end
            DONE: state_n = bus.done_ack ? FILL : DONE;
            default: begin
                state_n = FILL;
                cnt_n = '0;
            end
        endcase
    end
    // lane i shows buf[t-i][i]; the t >= i guard keeps a negative step from wrapping onto an entry
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam logic [CW-1:0] LANE = CW'(i);
        logic [CW-1:0] idx;
        assign idx = cnt_n - LANE;
        assign feed_n[i*DATA_SIZE +: DATA_SIZE] =
            state_n == STREAM && cnt_n >= LANE && idx < DEPTH_C ? mem[idx[IW-1:0]][i*DATA_SIZE +: DATA_SIZE] : '0;
    end
    always_ff @(posedge clk)
        if (accept) mem[cnt[IW-1:0]] <= bus.wr_data;
    // outputs are registered from the next state so each one lines up with its state cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FILL;
            cnt <= '0;
            bus.wr_ready <= 1'b1;
            bus.array_clear <= 1'b0;
            bus.feed_valid <= 1'b0;
            bus.feed_data <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bus.wr_ready <= state_n == FILL;
            bus.array_clear <= state_n == CLEAR;
            bus.feed_valid <= state_n == STREAM;
            bus.feed_data <= feed_n;
            bus.busy <= state_n != FILL;
            bus.done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: table and reference-model checks of systolic_feeder (DEPTH=4 and DEPTH=1 instances)
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    systolic_feeder_if #(.DATA_SIZE(8), .DIM(4)) m();
    systolic_feeder_if #(.DATA_SIZE(8), .DIM(4)) m1();
    systolic_feeder #(.DATA_SIZE(8), .DIM(4), .DEPTH(4)) u0 (.clk(clk), .reset(reset), .bus(m.slave));
    systolic_feeder #(.DATA_SIZE(8), .DIM(4), .DEPTH(1)) u1 (.clk(clk), .reset(reset), .bus(m1.slave));
    // ctrl = {array_clear, feed_valid, busy, done, wr_ready}
    typedef struct {
        int off;
        logic [4:0] ctrl;
        logic [31:0] feed;
    } row_t;
    row_t tbl [13];
    int pass_cnt = 0;
    int total = 0;
    logic [31:0] cap [16];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else pass_cnt++;
    endtask
    function automatic logic [36:0] obs(input bit w);
        return w ? {m1.array_clear, m1.feed_valid, m1.busy, m1.done, m1.wr_ready, m1.feed_data}
                 : {m.array_clear, m.feed_valid, m.busy, m.done, m.wr_ready, m.feed_data};
    endfunction
    task automatic drv(input bit w, input bit v, input logic [31:0] d, input bit a);
        if (w) begin
            m1.wr_valid = v; m1.wr_data = d; m1.done_ack = a;
        end else begin
            m.wr_valid = v; m.wr_data = d; m.done_ack = a;
        end
    endtask
    // reference: step t, lane i carries vector (t-i) lane i when that vector exists
    function automatic logic [31:0] model_feed(input int t, input int d, input logic [31:0] v [4]);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            int j = t - i;
            if (j >= 0 && j < d) r[i*8 +: 8] = v[j][i*8 +: 8];
        end
        return r;
    endfunction
    function automatic logic [4:0] model_ctrl(input int o, input int d);
        return o == 0 ? 5'b10100 : o <= d + 3 ? 5'b01100 : o <= d + 7 ? 5'b00100 : 5'b00110;
    endfunction
    // mode 0: back-to-back, 1: valid toggles 1,0,1,..., 2: random valid; returns at the CLEAR cycle
    task automatic fill(input bit w, input int d, input logic [31:0] v [4], input int mode);
        int k = 0;
        int n = 0;
        bit val;
        logic [36:0] ob;
        while (k < d && n < 200) begin
            @(negedge clk);
            ob = obs(w);
            chk("fill_ready_noclear", {ob[36], ob[32]}, 2'b01);
            val = mode == 0 ? 1'b1 : mode == 1 ? (n % 2 == 0) : 1'($urandom_range(0, 1));
            drv(w, val, val ? v[k] : $urandom, 1'b0);
            k += int'(val);
            n++;
        end
        if (k < d) chk("fill_timeout", 64'(k), 64'(d));
        @(negedge clk);
        drv(w, 1'b0, 32'h0, 1'b0);
        ob = obs(w);
        chk("clear_after_last_accept", ob[36], 1'b1);
    endtask
    task automatic capture(input bit w, input int d, input logic [31:0] v [4], input bit use_tbl, input bit noise);
        logic [36:0] ob;
        for (int o = 0; o <= d + 8; o++) begin
            if (o > 0) @(negedge clk);
            ob = obs(w);
            cap[o] = ob[31:0];
            chk($sformatf("ctrl@C+%0d", o), ob[36:32], use_tbl ? tbl[o].ctrl : model_ctrl(o, d));
            chk($sformatf("feed@C+%0d", o), ob[31:0],
                use_tbl ? tbl[o].feed : (o >= 1 && o <= d + 3) ? model_feed(o - 1, d, v) : 32'h0);
            drv(w, noise, $urandom, o < d + 8 ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    endtask
    task automatic ack(input bit w, input int n, input bit noise);
        logic [36:0] ob;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            ob = obs(w);
            chk("done_hold", {ob[33], ob[32]}, 2'b10);
            drv(w, noise, $urandom, 1'b0);
        end
        drv(w, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        ob = obs(w);
        drv(w, 1'b0, 32'h0, 1'b0);
        chk("done_drop_busy_done_ready", ob[34:32], 3'b001);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] va [4];
        logic [31:0] vr [4];
        logic [31:0] v1 [4];
        logic [31:0] d1 [4];
        logic [36:0] ob;
        int bad;
        tbl[0] = '{0, 5'b10100, 32'h0};
        tbl[1] = '{1, 5'b01100, 32'h00000000};
        tbl[2] = '{2, 5'b01100, 32'h00000110};
        tbl[3] = '{3, 5'b01100, 32'h00021120};
        tbl[4] = '{4, 5'b01100, 32'h03122130};
        tbl[5] = '{5, 5'b01100, 32'h13223100};
        tbl[6] = '{6, 5'b01100, 32'h23320000};
        tbl[7] = '{7, 5'b01100, 32'h33000000};
        for (int o = 8; o < 12; o++) tbl[o] = '{o, 5'b00100, 32'h0};
        tbl[12] = '{12, 5'b00110, 32'h0};
        va = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
        v1 = '{32'hA3A2A1A0, 32'h0, 32'h0, 32'h0};
        d1 = '{32'h000000A0, 32'h0000A100, 32'h00A20000, 32'hA3000000};
        drv(1'b0, 1'b0, 32'h0, 1'b0);
        drv(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_state_u0", obs(1'b0), 37'h100000000);
        chk("reset_state_u1", obs(1'b1), 37'h100000000);
        reset = 1'b1;
        fill(1'b0, 4, va, 0);
        capture(1'b0, 4, va, 1'b1, 1'b0);
        ack(1'b0, 10, 1'b0);
        fill(1'b0, 4, va, 1);
        capture(1'b0, 4, va, 1'b1, 1'b0);
        ack(1'b0, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) vr[k] = $urandom;
            fill(1'b0, 4, vr, 2);
            capture(1'b0, 4, vr, 1'b0, 1'b1);
            ack(1'b0, $urandom_range(0, 3), 1'b1);
        end
        for (int k = 0; k < 4; k++) vr[k] = $urandom;
        fill(1'b0, 4, vr, 0);
        for (int o = 1; o <= 3; o++) begin
            @(negedge clk);
            ob = obs(1'b0);
            chk($sformatf("pre_abort_feed@C+%0d", o), ob[31:0], model_feed(o - 1, 4, vr));
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_state", obs(1'b0), 37'h100000000);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            ob = obs(1'b0);
            if (ob[36] || ob[35] || !ob[32] || ob[31:0] != 32'h0) bad++;
        end
        chk("idle_after_abort", 64'(bad), 64'd0);
        for (int k = 0; k < 4; k++) vr[k] = $urandom;
        fill(1'b0, 4, vr, 2);
        capture(1'b0, 4, vr, 1'b0, 1'b0);
        ack(1'b0, 1, 1'b0);
        fill(1'b1, 1, v1, 0);
        capture(1'b1, 1, v1, 1'b0, 1'b0);
        for (int t = 0; t < 4; t++) chk($sformatf("depth1_step%0d", t), cap[t+1], d1[t]);
        ack(1'b1, 2, 1'b0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
